// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller turning EXE/MEM ops into multi-cycle word-port transactions with SB as read-modify-write
module mem_stage_ctrl #(
  parameter int MEM_AW = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cache_en,
  input  logic              mem_to_reg,
  input  logic              mem_write,
  input  logic              is_byte,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic              freeze,
  output logic [31:0]       load_data,
  output logic              misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_t;
  state_t state_q, state_d;
  logic access, mis_word, op_byte_q;
  logic [1:0] lane_q;
  logic [7:0] sbyte_q, rbyte;
  logic [31:0] merged;
  logic unused_addr;
  assign unused_addr = ^addr[31:MEM_AW+2];
  assign access = cache_en & (mem_write | mem_to_reg);
  assign mis_word = !is_byte & |addr[1:0];
  assign freeze = (state_q == IDLE & access) | state_q == RD | state_q == RMW_RD | state_q == WR;
  assign rbyte = mem_rdata[{lane_q, 3'b000} +: 8];
  always_comb begin
    merged = mem_rdata;
    merged[{lane_q, 3'b000} +: 8] = sbyte_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !access ? IDLE : mis_word ? DONE : !mem_write ? RD : is_byte ? RMW_RD : WR;
      RD:      state_d = mem_ack ? DONE : RD;
      RMW_RD:  state_d = mem_ack ? WR : RMW_RD;
      WR:      state_d = mem_ack ? DONE : WR;
      default: state_d = IDLE;
    endcase
  end
  // Op fields are captured at issue so later input changes cannot disturb the access
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q    <= IDLE;
      load_data  <= '0;
      misaligned <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      op_byte_q  <= 1'b0;
      lane_q     <= '0;
      sbyte_q    <= '0;
    end else begin
      state_q    <= state_d;
      misaligned <= state_q == IDLE & access & mis_word;
      case (state_q)
        IDLE: if (access & !mis_word) begin
          mem_req   <= 1'b1;
          mem_we    <= mem_write & !is_byte;
          mem_addr  <= addr[MEM_AW+1:2];
          mem_wdata <= store_data;
          op_byte_q <= is_byte;
          lane_q    <= addr[1:0];
          sbyte_q   <= store_data[7:0];
        end
        RD: if (mem_ack) begin
          mem_req   <= 1'b0;
          load_data <= op_byte_q ? {{24{rbyte[7]}}, rbyte} : mem_rdata;
        end
        RMW_RD: if (mem_ack) begin
          mem_we    <= 1'b1;
          mem_wdata <= merged;
        end
        WR: if (mem_ack) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage access controller. It sits on the consuming side of the EXE/MEM pipeline register and turns that register's held outputs into transactions on a multi-cycle word memory port. It drives `freeze` back to the pipeline registers so they hold until the access finishes. Supports LW/SW and LB/SB; SB is done as a read-modify-write.

Parameters:
- MEM_AW, 16, word-address width of the memory port; `addr[MEM_AW+1:2]` is used and the upper address bits are ignored.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst_b  input  1  asynchronous, active-high reset (1 = reset)
- cache_en  input  1  access enable from EXE/MEM; no access when 0
- mem_to_reg  input  1  load request
- mem_write  input  1  store request; if both mem_write and mem_to_reg are 1, the store wins
- is_byte  input  1  byte op (LB/SB) when 1, word op when 0
- addr  input  32  byte address (ALU result)
- store_data  input  32  store value; SB uses `[7:0]`
- freeze  output  1  stall for the pipeline registers (combinational)
- load_data  output  32  registered load result
- misaligned  output  1  one-cycle pulse on a word access with `addr[1:0] != 0`
- mem_req  output  1  transaction request (registered)
- mem_we  output  1  1 = write transaction
- mem_addr  output  MEM_AW  word address
- mem_wdata  output  32  write data
- mem_rdata  input  32  read data, valid when mem_ack = 1
- mem_ack  input  1  one-cycle completion strobe

Behaviour:
- `access = cache_en & (mem_write | mem_to_reg)`.
- Reset values: all registered outputs 0, state IDLE. Reset mid-transaction drops `mem_req` immediately (asynchronously) and abandons the access; no write is retried.
- States: IDLE, RD, RMW_RD, WR, DONE.
- IDLE:
  - If `access` and the op is a misaligned word op: pulse `misaligned`, go to DONE, issue no transaction, leave `load_data` unchanged.
  - Else if `access`, next state and first transaction:
    - load → RD (`mem_req=1`, `mem_we=0`)
    - SW → WR (`mem_we=1`, `mem_wdata=store_data`)
    - SB → RMW_RD (`mem_we=0`)
- RD: on `mem_ack`, capture `load_data` and go to DONE.
  - LW: `load_data = mem_rdata`.
  - LB: select byte lane `addr[1:0]` (little-endian: lane 0 = `[7:0]`) and sign-extend it to 32 bits.
- RMW_RD: on `mem_ack`, go to WR with `mem_wdata` = `mem_rdata` with lane `addr[1:0]` replaced by `store_data[7:0]`. `mem_req` stays 1 back-to-back; `mem_we` becomes 1 the cycle after the ack.
- WR: on `mem_ack`, go to DONE.
- DONE: `freeze=0` and `mem_req=0`; always returns to IDLE the next cycle. The pipeline advances at the end of the DONE cycle, so a held op is never re-issued.
- `freeze = (IDLE & access) | RD | RMW_RD | WR`. It is 0 in DONE and 0 in IDLE with no access.
- Handshake:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable while `mem_req=1` and no `mem_ack` has arrived.
  - A new transaction may start in the cycle after an ack.
  - `mem_ack` while `mem_req=0` is ignored.
- Inputs are sampled only in IDLE. Changes on them while `freeze=1` are protocol violations; the captured op is used.
- Latency:
  - load with ack on the k-th request cycle: `freeze` high for k+1 cycles, `load_data` valid from DONE onward.
  - SB costs two transactions.
  - Misaligned word op: `freeze` high for 1 cycle.
- `load_data` holds its value until the next load completes; stores do not change it.

Test Plan:
- Reset with rst_b=1 mid-RD → `mem_req`=0 at once, state IDLE, `freeze`=0 with cache_en=0, `load_data`=0.
- LW addr=0x0000_0010, memory returns 0xDEADBEEF after 3 cycles → `mem_addr`=4, `mem_we`=0, `freeze` high 4 cycles, then `load_data`=0xDEADBEEF with `freeze`=0 in DONE.
- LB addr=0x13, word 0x80FF_1234 → `load_data`=0xFFFF_FF80; LB addr=0x10 on the same word → 0x0000_0034.
- SB addr=0x21, store_data=0xAA, memory word 0x1122_3344 → read then write of 0x1122_AA44 to `mem_addr`=8; `load_data` unchanged.
- SW addr=0x06 → `misaligned` pulses once, no `mem_req`, `freeze` high exactly 1 cycle.
- Back-to-back LW then SW with ack latency 1 → each op issues exactly one transaction, no duplicate after DONE, `mem_req` low in DONE between them.
